// File: rtl/formula_sweep_pkg.sv
// Shared definitions for the formula sweep driver: state encoding, default
// widths and a saturating counter helper.
// Imported by the driver and by any parent that sizes its evaluator from it.
package formula_sweep_pkg;

  localparam int VEC_W_DEF   = 61;
  localparam int SWEEP_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  // 16-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/formula_sweep_driver.sv
// Enumerates the low SWEEP_W bits of an assignment vector over a fixed base,
// reports each failing assignment on a valid/ready handshake.
// Latency: one vector per cycle; done_o pulses 2^SWEEP_W+1 cycles after start
// when nothing fails. Backpressure: sweep stalls in REPORT until cex_ready_i.
module formula_sweep_driver
  import formula_sweep_pkg::*;
#(
  parameter int VEC_W   = VEC_W_DEF,
  parameter int SWEEP_W = SWEEP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               cont_i,
  input  logic               abort_i,
  input  logic [VEC_W-1:0]   base_i,
  output logic [VEC_W-1:0]   vec_o,
  input  logic               result_i,
  output logic               cex_valid_o,
  input  logic               cex_ready_i,
  output logic [VEC_W-1:0]   cex_vec_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic               aborted_o,
  output logic [15:0]        cex_cnt_o,
  output logic [SWEEP_W:0]   checked_o
);

  localparam int                 CHK_W    = SWEEP_W + 1;
  localparam logic [SWEEP_W-1:0] CNT_LAST = '1;
  // Bits of the vector owned by the sweep counter
  localparam logic [VEC_W-1:0]   LOW_MASK = VEC_W'((64'd1 << SWEEP_W) - 64'd1);

  sweep_state_t       r_state;
  logic [VEC_W-1:0]   r_base;
  logic               r_cont;
  logic [SWEEP_W-1:0] r_cnt;
  logic [VEC_W-1:0]   r_vec;
  logic [VEC_W-1:0]   r_cex_vec;
  logic               r_cex_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic               r_aborted;
  logic [15:0]        r_cex_cnt;
  logic [CHK_W-1:0]   r_checked;

  logic [SWEEP_W-1:0] w_cnt_inc;
  logic [VEC_W-1:0]   w_vec_inc;
  logic               w_cnt_last;

  assign w_cnt_inc  = r_cnt + SWEEP_W'(1);
  assign w_vec_inc  = r_base | VEC_W'(w_cnt_inc);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Sweep controller: state, counter, status and the registered outputs.
  // done_o is raised while leaving DONE, so it trails the DONE state by one
  // register stage and lands 2^SWEEP_W+1 cycles after the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_cont      <= 1'b0;
      r_cnt       <= '0;
      r_vec       <= '0;
      r_cex_vec   <= '0;
      r_cex_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_aborted   <= 1'b0;
      r_cex_cnt   <= '0;
      r_checked   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_base    <= base_i & ~LOW_MASK;
            r_vec     <= base_i & ~LOW_MASK;
            r_cont    <= cont_i;
            r_cnt     <= '0;
            r_cex_cnt <= '0;
            r_checked <= '0;
            r_pass    <= 1'b0;
            r_aborted <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            r_aborted   <= 1'b1;
            r_pass      <= 1'b0;
            r_cex_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_DONE;
          end else begin
            r_checked <= r_checked + CHK_W'(1);
            if (result_i) begin
              if (!w_cnt_last) begin
                r_cnt <= w_cnt_inc;
                r_vec <= w_vec_inc;
              end else begin
                r_pass  <= (r_cex_cnt == 16'd0);
                r_busy  <= 1'b0;
                r_state <= ST_DONE;
              end
            end else begin
              r_cex_vec   <= r_vec;
              r_cex_cnt   <= sat_inc16(r_cex_cnt);
              r_cex_valid <= 1'b1;
              r_state     <= ST_REPORT;
            end
          end
        end
        ST_REPORT: begin
          // Abort wins over a handshake arriving in the same cycle
          if (abort_i) begin
            r_aborted   <= 1'b1;
            r_pass      <= 1'b0;
            r_cex_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_DONE;
          end else if (cex_ready_i) begin
            r_cex_valid <= 1'b0;
            if (r_cont && !w_cnt_last) begin
              r_cnt   <= w_cnt_inc;
              r_vec   <= w_vec_inc;
              r_state <= ST_RUN;
            end else begin
              r_pass  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign vec_o       = r_vec;
  assign cex_vec_o   = r_cex_vec;
  assign cex_valid_o = r_cex_valid;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign aborted_o   = r_aborted;
  assign cex_cnt_o   = r_cex_cnt;
  assign checked_o   = r_checked;

endmodule

// File: tb/tb_formula_sweep_driver.sv
// Self-checking bench for formula_sweep_driver: directed scenarios plus
// randomized sweeps against a vector-enumerating reference model.
module tb_formula_sweep_driver;

  localparam int VW = 61;
  localparam int SW = 10;
  localparam int NV = 1 << SW;

  logic          clk = 1'b0;
  logic          rst, start_i, cont_i, abort_i, cex_ready_i, result_i;
  logic [VW-1:0] base_i, vec_o, cex_vec_o;
  logic          cex_valid_o, busy_o, done_o, pass_o, aborted_o;
  logic [15:0]   cex_cnt_o;
  logic [SW:0]   checked_o;

  // Formula under test: fails where the masked vector equals f_val
  logic [VW-1:0] f_mask, f_val;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  int cyc    = 0;

  logic [VW-1:0] exp_q[$];
  int            exp_checked;
  logic          exp_pass;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign result_i = ((vec_o & f_mask) != f_val);

  formula_sweep_driver #(.VEC_W(VW), .SWEEP_W(SW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cont_i(cont_i),
    .abort_i(abort_i), .base_i(base_i), .vec_o(vec_o), .result_i(result_i),
    .cex_valid_o(cex_valid_o), .cex_ready_i(cex_ready_i),
    .cex_vec_o(cex_vec_o), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .aborted_o(aborted_o), .cex_cnt_o(cex_cnt_o),
    .checked_o(checked_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic formula(input logic [VW-1:0] v);
    return ((v & f_mask) != f_val);
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[VW-1:0];
  endfunction

  // Reference: walk every assignment in order, collect failures, stop early
  // at the first one unless continuing.
  task automatic model(input logic [VW-1:0] base, input logic cont);
    logic [VW-1:0] v;
    logic [SW-1:0] low;
    exp_q.delete();
    exp_checked = 0;
    for (int i = 0; i < NV; i++) begin
      low = SW'(i);
      v = {base[VW-1:SW], low};
      exp_checked++;
      if (!formula(v)) begin
        exp_q.push_back(v);
        if (!cont) break;
      end
    end
    exp_pass = (exp_q.size() == 0);
  endtask

  // One full sweep with a ready policy; stall<0 picks 0..3 per report
  task automatic run_sweep(input string tag, input logic [VW-1:0] base,
                           input logic cont, input int stall, input bit inject);
    int   idx, stall_left, t0;
    bit   stalling, hs;
    logic [VW-1:0] zero_low;
    model(base, cont);
    zero_low = {base[VW-1:SW], {SW{1'b0}}};
    start_i = 1'b1; cont_i = cont; base_i = base;
    tick();
    start_i = 1'b0; base_i = rand_vec(); cont_i = ~cont;
    t0 = cyc;
    check({tag, " busy_after_start"}, 64'(busy_o), 64'd1);
    check({tag, " vec_first"}, 64'(vec_o), 64'(zero_low));
    idx = 0; stalling = 0; hs = 0; stall_left = 0;
    for (int k = 0; k < 20000 && !done_o; k++) begin
      start_i = (inject && k == 3);
      if (inject && k == 3) base_i = ~base;
      if (inject && k == 6)
        check({tag, " upper_bits_kept"}, 64'(vec_o[VW-1:SW]), 64'(base[VW-1:SW]));
      if (cex_valid_o) begin
        if (idx < exp_q.size()) check({tag, " cex_vec"}, 64'(cex_vec_o), 64'(exp_q[idx]));
        else check({tag, " unexpected_cex"}, 64'd1, 64'd0);
        if (!stalling) begin
          stalling = 1;
          stall_left = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
        end
        if (stall_left == 0) begin
          cex_ready_i = 1'b1; hs = 1;
        end else begin
          stall_left--; cex_ready_i = 1'b0;
        end
      end else begin
        cex_ready_i = 1'b0;
      end
      tick();
      start_i = 1'b0;
      if (hs) begin
        idx++; hs = 0; stalling = 0; cex_ready_i = 1'b0;
      end
    end
    check({tag, " done_seen"}, 64'(done_o), 64'd1);
    if (exp_pass) check({tag, " latency"}, 64'(cyc - t0), 64'(NV + 1));
    check({tag, " pass"}, 64'(pass_o), 64'(exp_pass));
    check({tag, " aborted"}, 64'(aborted_o), 64'd0);
    check({tag, " checked"}, 64'(checked_o), 64'(exp_checked));
    check({tag, " cex_cnt"}, 64'(cex_cnt_o), 64'(exp_q.size()));
    check({tag, " reports"}, 64'(idx), 64'(exp_q.size()));
    check({tag, " busy_end"}, 64'(busy_o), 64'd0);
    tick();
    check({tag, " done_pulse"}, 64'(done_o), 64'd0);
    check({tag, " pass_held"}, 64'(pass_o), 64'(exp_pass));
  endtask

  initial begin
    logic [VW-1:0] b;
    logic [SW-1:0] ml;
    int            dcnt;
    bit            hit;

    rst = 1'b1; start_i = 1'b0; cont_i = 1'b0; abort_i = 1'b0;
    cex_ready_i = 1'b0; base_i = '0; f_mask = '0; f_val = 61'd1;
    tick(); tick();
    rst = 1'b0;
    check("rst vec", 64'(vec_o), 64'd0);
    check("rst cex_valid", 64'(cex_valid_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst done", 64'(done_o), 64'd0);
    check("rst checked", 64'(checked_o), 64'd0);
    check("rst cex_cnt", 64'(cex_cnt_o), 64'd0);
    tick();

    // All assignments satisfy the formula
    f_mask = '0; f_val = 61'd1;
    run_sweep("allpass", rand_vec(), 1'b0, 0, 0);

    // Stop at first counterexample (low nibble == 5)
    f_mask = 61'hF; f_val = 61'h5;
    run_sweep("first_cex", '0, 1'b0, 0, 0);
    check("first_cex vec", 64'(cex_vec_o), 64'd5);

    // Continue through all 64 counterexamples with stalls, ignored restart
    run_sweep("cont_stall", '0, 1'b1, 3, 1);

    // Abort together with the handshake in REPORT
    b = rand_vec();
    start_i = 1'b1; cont_i = 1'b1; base_i = b;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 50 && !cex_valid_o; k++) tick();
    check("abort report_seen", 64'(cex_valid_o), 64'd1);
    tick(); tick();
    check("abort stable", 64'(cex_vec_o), 64'({b[VW-1:SW], 10'd5}));
    abort_i = 1'b1; cex_ready_i = 1'b1;
    tick();
    abort_i = 1'b0; cex_ready_i = 1'b0;
    check("abort valid_drop", 64'(cex_valid_o), 64'd0);
    check("abort busy", 64'(busy_o), 64'd0);
    check("abort aborted", 64'(aborted_o), 64'd1);
    check("abort pass", 64'(pass_o), 64'd0);
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done_o) dcnt++;
    end
    check("abort done_once", 64'(dcnt), 64'd1);
    check("abort no_resume", 64'(vec_o[SW-1:0]), 64'd5);
    check("abort checked", 64'(checked_o), 64'd6);
    check("abort cex_cnt", 64'(cex_cnt_o), 64'd1);

    // Reset in the middle of a sweep
    f_mask = '0; f_val = 61'd1;
    start_i = 1'b1; cont_i = 1'b0; base_i = rand_vec();
    tick();
    start_i = 1'b0;
    hit = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      if (vec_o[SW-1:0] == SW'(300)) hit = 1;
      else tick();
    end
    check("midrst reached_300", 64'(hit), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst vec", 64'(vec_o), 64'd0);
    check("midrst cex_vec", 64'(cex_vec_o), 64'd0);
    check("midrst flags", 64'({cex_valid_o, busy_o, done_o, pass_o, aborted_o}), 64'd0);
    check("midrst cex_cnt", 64'(cex_cnt_o), 64'd0);
    check("midrst checked", 64'(checked_o), 64'd0);
    tick();
    check("midrst idle", 64'({busy_o, done_o}), 64'd0);
    run_sweep("after_rst", rand_vec(), 1'b0, 0, 0);

    // Randomized formulas, bases, continue modes and stalls
    for (int it = 0; it < 4; it++) begin
      b = rand_vec();
      ml = SW'($urandom() & $urandom());
      f_mask = rand_vec() & ~VW'(NV - 1);
      f_mask = f_mask | VW'(ml);
      f_val = rand_vec() & f_mask;
      if ($urandom_range(3, 0) != 0)
        f_val = (f_val & VW'(NV - 1)) | (b & f_mask & ~VW'(NV - 1));
      run_sweep($sformatf("rand%0d", it), b, 1'($urandom_range(1, 0)), -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/formula_sweep_driver.md
FORMULA_SWEEP_DRIVER -- requirements
Module: formula_sweep_driver

Interface
REQ-001 SHALL have parameter VEC_W, default 61: width of the assignment vector driven into the formula evaluator.
REQ-002 SHALL have parameter SWEEP_W, default 10: number of low vector bits enumerated, legal range 1..16.
REQ-003 SHALL use one clock and a reset that is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start_i  in  1  one-cycle pulse that begins a sweep; honoured only in IDLE.
REQ-007 cont_i  in  1  sampled with start_i; 1 = continue after each counterexample, 0 = stop at the first.
REQ-008 abort_i  in  1  terminates a sweep in RUN or REPORT.
REQ-009 base_i  in  VEC_W  fixed assignment, sampled with start_i.
REQ-010 vec_o  out  VEC_W  registered assignment; bit 0 drives v_1, bit VEC_W-1 drives v_VEC_W.
REQ-011 result_i  in  1  combinational formula verdict (o_1) for the current vec_o.
REQ-012 cex_valid_o / cex_ready_i  out/in  1/1  counterexample handshake.
REQ-013 cex_vec_o  out  VEC_W  captured failing assignment, stable while cex_valid_o=1.
REQ-014 busy_o  out  1  high in RUN or REPORT.
REQ-015 done_o  out  1  one-cycle pulse at sweep end.
REQ-016 pass_o, aborted_o  out  1/1  sweep status, held until the next accepted start.
REQ-017 cex_cnt_o  out  16  counterexamples found, saturating at 0xFFFF.
REQ-018 checked_o  out  SWEEP_W+1  number of assignments evaluated.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, REPORT, DONE.
REQ-020 On start_i in IDLE, the block SHALL latch base_i and cont_i, clear the counter, cex_cnt_o, checked_o, pass_o and aborted_o, and enter RUN on the next edge.
REQ-021 In RUN, vec_o SHALL equal the latched base with bits [SWEEP_W-1:0] replaced by the counter; the higher bits SHALL stay unchanged.
REQ-022 In each RUN cycle the block SHALL sample result_i and increment checked_o.
REQ-023 If result_i=1 and the counter is below 2^SWEEP_W-1, the counter SHALL increment.
REQ-024 If result_i=1 at the last counter value, the block SHALL enter DONE with pass_o=1 when cex_cnt_o=0, else pass_o=0.
REQ-025 If result_i=0, the block SHALL capture vec_o into cex_vec_o, increment cex_cnt_o (saturating), and enter REPORT with cex_valid_o=1.
REQ-026 REPORT SHALL hold cex_valid_o and cex_vec_o until cex_ready_i=1; cex_ready_i may already be high on entry.
REQ-027 On the REPORT handshake: if cont_i was latched as 1 and the counter is not last, the counter SHALL increment and the block SHALL return to RUN; otherwise it SHALL enter DONE with pass_o=0.
REQ-028 abort_i in RUN or REPORT SHALL enter DONE with aborted_o=1 and pass_o=0, drop cex_valid_o, and take priority over a simultaneous handshake or verdict.
REQ-029 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-030 start_i outside IDLE SHALL be ignored.
REQ-031 Latency: with no counterexample, done_o SHALL assert exactly 2^SWEEP_W+1 cycles after the start edge.
REQ-032 The counter SHALL never wrap.

Reset
REQ-033 rst SHALL, at any state including mid-sweep, force IDLE and zero vec_o, cex_vec_o, cex_valid_o, busy_o, done_o, pass_o, aborted_o, cex_cnt_o, checked_o and the counter on the next edge.

Structure
REQ-034 The shared package formula_sweep_pkg SHALL hold the state enum, the VEC_W default of 61 and the SWEEP_W default of 10.
REQ-035 The block SHALL contain no sub-module; the formula evaluator SHALL be instantiated beside it at the parent level.

Verification
REQ-036 Scenario: model result=1 for all vectors, SWEEP_W=10 -> done_o asserts 1025 cycles after start, pass_o=1, checked_o=1024, cex_cnt_o=0.
REQ-037 Scenario: model result=(vec[3:0]!=5), cont=0, base=0 -> cex_vec_o=5, cex_cnt_o=1, pass_o=0, checked_o=6.
REQ-038 Scenario: same model with cont=1 and cex_ready_i held low for 3 cycles per report -> 64 counterexamples, cex_cnt_o=64, checked_o=1024, cex_vec_o stable while stalled.
REQ-039 Scenario: abort_i asserted in the same cycle as cex_ready_i in REPORT -> aborted_o=1, no resume, done_o pulses once.
REQ-040 Scenario: rst at counter=300 during RUN -> all outputs zero next cycle; a new start sweeps from 0.
REQ-041 Scenario: start_i pulsed while busy_o=1 with a different base_i -> no effect on vec_o upper bits.
